// File: rtl/cdf_accumulator.sv
// In-place saturating prefix sum over the scratch-memory histogram: one bin pair
// is read every two cycles and written back at one bin per cycle.
module cdf_accumulator #(
  parameter int BINS   = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cdf_en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cdf_scratch_mem_raddr0,
  output logic [ADDR_W-1:0] cdf_scratch_mem_raddr1,
  input  logic [DATA_W-1:0] cdf_scratch_mem_rdata0,
  input  logic [DATA_W-1:0] cdf_scratch_mem_rdata1,
  output logic [ADDR_W-1:0] cdf_scratch_mem_waddr,
  output logic [DATA_W-1:0] cdf_scratch_mem_wdata,
  output logic              cdf_scratch_mem_WE,
  output logic [DATA_W-1:0] cdf_min,
  output logic [DATA_W-1:0] cdf_total,
  output logic              cdf_overflow
);
  localparam int PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(BINS / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic [PAIR_W-1:0] pair_reg;
  logic [PAIR_W-1:0] pair_inc;
  logic              phase_reg;
  logic              drain_reg;
  logic              min_found_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] wr_value;
  logic              launch;
  logic              even_write;
  logic              odd_write;

  assign launch   = (state_reg == IDLE) && start && cdf_en;
  assign pair_inc = pair_reg + PAIR_W'(1);

  // Even bin is written the cycle its read data arrives; the odd bin follows
  // from the held rdata1, so pair 0 has no odd write pending in its first phase.
  assign even_write = cdf_en && (state_reg == RUN) && phase_reg;
  assign odd_write  = cdf_en && (((state_reg == RUN) && !phase_reg && (pair_reg != '0)) ||
                                 ((state_reg == DRAIN) && !drain_reg));

  assign addend   = even_write ? cdf_scratch_mem_rdata0 : hold_reg;
  assign sum      = {1'b0, acc_reg} + {1'b0, addend};
  assign wr_value = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!cdf_en) begin
          state_next = IDLE;
        end else if (phase_reg && (pair_reg == LAST_PAIR)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!cdf_en) begin
          state_next = IDLE;
        end else if (drain_reg) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_reg               <= '0;
      phase_reg              <= 1'b0;
      drain_reg              <= 1'b0;
      min_found_reg          <= 1'b0;
      acc_reg                <= '0;
      hold_reg               <= '0;
      cdf_scratch_mem_raddr0 <= '0;
      cdf_scratch_mem_raddr1 <= '0;
      cdf_scratch_mem_waddr  <= '0;
      cdf_scratch_mem_wdata  <= '0;
      cdf_scratch_mem_WE     <= 1'b0;
      cdf_min                <= '0;
      cdf_total              <= '0;
      cdf_overflow           <= 1'b0;
    end else begin
      if (launch) begin
        pair_reg               <= '0;
        phase_reg              <= 1'b0;
        drain_reg              <= 1'b0;
        min_found_reg          <= 1'b0;
        acc_reg                <= '0;
        cdf_min                <= '0;
        cdf_total              <= '0;
        cdf_overflow           <= 1'b0;
        cdf_scratch_mem_raddr0 <= '0;
        cdf_scratch_mem_raddr1 <= ADDR_W'(1);
      end

      if ((state_reg == RUN) && cdf_en) begin
        phase_reg <= ~phase_reg;
      end
      if (state_reg == DRAIN) begin
        drain_reg <= 1'b1;
      end

      if (even_write) begin
        hold_reg <= cdf_scratch_mem_rdata1;
        if (pair_reg != LAST_PAIR) begin
          pair_reg               <= pair_inc;
          cdf_scratch_mem_raddr0 <= {pair_inc, 1'b0};
          cdf_scratch_mem_raddr1 <= {pair_inc, 1'b1};
        end
      end

      if (even_write || odd_write) begin
        acc_reg               <= wr_value;
        cdf_scratch_mem_wdata <= wr_value;
        cdf_scratch_mem_waddr <= even_write ? {pair_reg, 1'b0}
                                            : {cdf_scratch_mem_waddr[ADDR_W-1:1], 1'b1};
        if (sum[DATA_W]) begin
          cdf_overflow <= 1'b1;
        end
        if (!min_found_reg && (wr_value != '0)) begin
          cdf_min       <= wr_value;
          min_found_reg <= 1'b1;
        end
      end
      cdf_scratch_mem_WE <= even_write || odd_write;

      if ((state_reg == DRAIN) && cdf_en && drain_reg) begin
        cdf_total <= acc_reg;
      end
    end
  end

endmodule

// File: tb/tb_cdf_accumulator.sv
// Runs a 20-bit and an 8-bit instance side by side on shared control, each with its
// own scratch-memory model, and compares against a running-sum reference.
module tb_cdf_accumulator;
  localparam int BINS   = 256;
  localparam int ADDR_W = 8;
  localparam int DW_A   = 20;
  localparam int DW_B   = 8;
  localparam longint MAX_A = (64'd1 << DW_A) - 1;
  localparam longint MAX_B = (64'd1 << DW_B) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cdf_en, start, load;

  logic              busy_a, done_a, we_a, ovf_a;
  logic [ADDR_W-1:0] raddr0_a, raddr1_a, waddr_a;
  logic [DW_A-1:0]   rdata0_a, rdata1_a, wdata_a, min_a, total_a;
  logic              busy_b, done_b, we_b, ovf_b;
  logic [ADDR_W-1:0] raddr0_b, raddr1_b, waddr_b;
  logic [DW_B-1:0]   rdata0_b, rdata1_b, wdata_b, min_b, total_b;

  logic [DW_A-1:0] mem_a  [BINS];
  logic [DW_A-1:0] hist_a [BINS];
  logic [DW_B-1:0] mem_b  [BINS];
  logic [DW_B-1:0] hist_b [BINS];

  longint ref_a [BINS];
  longint ref_b [BINS];
  longint rmin_a, rtot_a, rmin_b, rtot_b;
  bit     rovf_a, rovf_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cdf_accumulator #(.BINS(BINS), .ADDR_W(ADDR_W), .DATA_W(DW_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cdf_en(cdf_en), .start(start),
    .busy(busy_a), .done(done_a),
    .cdf_scratch_mem_raddr0(raddr0_a), .cdf_scratch_mem_raddr1(raddr1_a),
    .cdf_scratch_mem_rdata0(rdata0_a), .cdf_scratch_mem_rdata1(rdata1_a),
    .cdf_scratch_mem_waddr(waddr_a), .cdf_scratch_mem_wdata(wdata_a),
    .cdf_scratch_mem_WE(we_a),
    .cdf_min(min_a), .cdf_total(total_a), .cdf_overflow(ovf_a)
  );

  cdf_accumulator #(.BINS(BINS), .ADDR_W(ADDR_W), .DATA_W(DW_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cdf_en(cdf_en), .start(start),
    .busy(busy_b), .done(done_b),
    .cdf_scratch_mem_raddr0(raddr0_b), .cdf_scratch_mem_raddr1(raddr1_b),
    .cdf_scratch_mem_rdata0(rdata0_b), .cdf_scratch_mem_rdata1(rdata1_b),
    .cdf_scratch_mem_waddr(waddr_b), .cdf_scratch_mem_wdata(wdata_b),
    .cdf_scratch_mem_WE(we_b),
    .cdf_min(min_b), .cdf_total(total_b), .cdf_overflow(ovf_b)
  );

  // Scratch memory: 1-cycle read latency; the arbiter only passes writes while cdf_en is high.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < BINS; i++) begin
        mem_a[i] <= hist_a[i];
        mem_b[i] <= hist_b[i];
      end
    end else begin
      if (cdf_en && we_a) mem_a[waddr_a] <= wdata_a;
      if (cdf_en && we_b) mem_b[waddr_b] <= wdata_b;
    end
    rdata0_a <= mem_a[raddr0_a];
    rdata1_a <= mem_a[raddr1_a];
    rdata0_b <= mem_b[raddr0_b];
    rdata1_b <= mem_b[raddr1_b];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference: running sum clamped at the width maximum.
  task automatic build_ref();
    longint ra, rb;
    ra = 0; rb = 0;
    rmin_a = 0; rmin_b = 0; rovf_a = 0; rovf_b = 0;
    for (int i = 0; i < BINS; i++) begin
      ra = ra + longint'(hist_a[i]);
      if (ra > MAX_A) begin ra = MAX_A; rovf_a = 1; end
      rb = rb + longint'(hist_b[i]);
      if (rb > MAX_B) begin rb = MAX_B; rovf_b = 1; end
      ref_a[i] = ra;
      ref_b[i] = rb;
      if (rmin_a == 0 && ra != 0) rmin_a = ra;
      if (rmin_b == 0 && rb != 0) rmin_b = rb;
    end
    rtot_a = ra;
    rtot_b = rb;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl_a"}, 64'({busy_a, done_a, we_a, ovf_a}), 64'd0);
    check({tag, "_addr_a"}, 64'({raddr0_a, raddr1_a, waddr_a}), 64'd0);
    check({tag, "_data_a"}, 64'({wdata_a, min_a, total_a}), 64'd0);
    check({tag, "_ctl_b"}, 64'({busy_b, done_b, we_b, ovf_b}), 64'd0);
    check({tag, "_addr_b"}, 64'({raddr0_b, raddr1_b, waddr_b}), 64'd0);
    check({tag, "_data_b"}, 64'({wdata_b, min_b, total_b}), 64'd0);
  endtask

  // Cycle 0 is the cycle start is sampled; outputs are sampled on the falling edge.
  task automatic run_pass(input string name, input int restart_c, input int abort_c,
                          input int reset_c);
    int       last_c;
    int       limit;
    int       err_before;
    bit       stopped;
    bit       active;
    logic [2:0] exp_ctl;
    longint   exp_a, exp_b;
    err_before = errors;
    build_ref();
    @(negedge clk);
    cyc = 0; load = 1'b1; start = 1'b1; cdf_en = 1'b1;
    last_c  = (abort_c != 0) ? BINS + 4 : BINS + 3;
    stopped = 0;
    for (int c = 1; c <= last_c && !stopped; c++) begin
      @(negedge clk);
      cyc  = c;
      load = 1'b0;
      if (reset_c != 0 && c == reset_c + 1) begin
        check_idle_outputs("midreset");
        rst_n   = 1'b1;
        start   = 1'b0;
        stopped = 1;
      end else begin
        active  = (abort_c == 0) || (c <= abort_c);
        exp_ctl = {active && c >= 1 && c <= BINS + 2,
                   active && c == BINS + 3,
                   active && c >= 3 && c <= BINS + 2};
        check("ctl_a", 64'({busy_a, done_a, we_a}), 64'(exp_ctl));
        check("ctl_b", 64'({busy_b, done_b, we_b}), 64'(exp_ctl));
        if (exp_ctl[0]) begin
          check("waddr_a", 64'(waddr_a), 64'(c - 3));
          check("wdata_a", 64'(wdata_a), 64'(ref_a[c-3]));
          check("waddr_b", 64'(waddr_b), 64'(c - 3));
          check("wdata_b", 64'(wdata_b), 64'(ref_b[c-3]));
        end
        if (active && (c % 2 == 1) && c <= BINS - 1) begin
          check("raddr0_a", 64'(raddr0_a), 64'(c - 1));
          check("raddr1_a", 64'(raddr1_a), 64'(c));
          check("raddr0_b", 64'(raddr0_b), 64'(c - 1));
        end
        if (exp_ctl[1]) begin
          check("min_a", 64'(min_a), 64'(rmin_a));
          check("total_a", 64'(total_a), 64'(rtot_a));
          check("ovf_a", 64'(ovf_a), 64'(rovf_a));
          check("min_b", 64'(min_b), 64'(rmin_b));
          check("total_b", 64'(total_b), 64'(rtot_b));
          check("ovf_b", 64'(ovf_b), 64'(rovf_b));
        end
        start = (c == restart_c) || (abort_c != 0 && c == abort_c + 5);
        if (abort_c != 0 && c == abort_c) cdf_en = 1'b0;
        if (reset_c != 0 && c == reset_c) rst_n = 1'b0;
      end
    end
    if (reset_c == 0) begin
      limit = (abort_c != 0) ? abort_c - 1 : BINS + 2;
      for (int i = 0; i < BINS; i++) begin
        exp_a = (i + 3 <= limit) ? ref_a[i] : longint'(hist_a[i]);
        exp_b = (i + 3 <= limit) ? ref_b[i] : longint'(hist_b[i]);
        check("mem_a", 64'(mem_a[i]), 64'(exp_a));
        check("mem_b", 64'(mem_b[i]), 64'(exp_b));
      end
    end
    $display("pass %s: total_a=%0d total_b=%0d new_errors=%0d", name, total_a, total_b,
             errors - err_before);
  endtask

  task automatic fill_random(input int max_a, input int max_b);
    for (int i = 0; i < BINS; i++) begin
      hist_a[i] = DW_A'($urandom_range(0, max_a));
      hist_b[i] = DW_B'($urandom_range(0, max_b));
    end
  endtask

  initial begin
    rst_n = 1'b0; cdf_en = 1'b0; start = 1'b0; load = 1'b0;
    for (int i = 0; i < BINS; i++) begin hist_a[i] = '0; hist_b[i] = '0; end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < BINS; i++) begin hist_a[i] = 1; hist_b[i] = 2; end
    run_pass("ones", 0, 0, 0);

    fill_random(0, 3);
    hist_a[5] = 7; hist_a[200] = 3;
    run_pass("sparse", 0, 0, 0);

    for (int i = 0; i < BINS; i++) begin hist_a[i] = '0; hist_b[i] = '0; end
    run_pass("zero", 0, 0, 0);

    fill_random(4095, 3);
    run_pass("restart_abort", 50, 100, 0);

    fill_random(4095, 3);
    run_pass("reset_mid", 0, 0, 80);

    fill_random(4095, 1);
    run_pass("after_reset", 0, 0, 0);

    fill_random(8191, 3);
    run_pass("rand_large", 0, 0, 0);

    fill_random(300, 0);
    run_pass("rand_small", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdf_accumulator.md
# cdf_accumulator

Computes the cumulative distribution function (CDF) of the 256-bin histogram held in scratch memory, in place, for the histogram-equalization datapath. It runs after the histogram stage and before the divider stage. It drives the cdf_scratch_mem_* port group of the scratch-memory arbiter, which routes that group to memory while cdf_en is high. It also reports cdf_min and cdf_total, which the divider stage uses for normalization.

## Interface
- BINS, 256: histogram bin count; power of two, ≥4.
- ADDR_W, 8: scratch address width; equals log2(BINS).
- DATA_W, 20: bin and accumulator width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cdf_en  in  1  stage enable from the top sequencer; level signal.
- start  in  1  one-cycle pulse; begins a pass.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- cdf_scratch_mem_raddr0  out  ADDR_W  read address, port 0 (even bin).
- cdf_scratch_mem_raddr1  out  ADDR_W  read address, port 1 (odd bin).
- cdf_scratch_mem_rdata0  in  DATA_W  read data, port 0.
- cdf_scratch_mem_rdata1  in  DATA_W  read data, port 1.
- cdf_scratch_mem_waddr  out  ADDR_W  write address.
- cdf_scratch_mem_wdata  out  DATA_W  write data (cumulative value).
- cdf_scratch_mem_WE  out  1  write enable; active high.
- cdf_min  out  DATA_W  first nonzero CDF value; 0 if the histogram is all zero.
- cdf_total  out  DATA_W  final CDF value (pixel count).
- cdf_overflow  out  1  sticky; set if the accumulator saturated during the pass.

## Operation
- States:
  - IDLE.
  - RUN: pair counter p from 0 to BINS/2-1, plus a phase bit.
  - DRAIN: last two writes.
  - DONE: one cycle.
- IDLE → RUN: start && cdf_en. At this point acc, cdf_min, cdf_total and cdf_overflow clear to 0, and the min_found flag clears.
- start is ignored while busy, and also ignored when cdf_en is low.
- Reads: raddr0=2p and raddr1=2p+1 are registered and presented together, one pair every 2 cycles.
- Memory read latency is 1 cycle: rdata for addresses presented in cycle c is valid in cycle c+1.
- Writes go back in place to the same bin address:
  - bin 2p gets acc+rdata0;
  - bin 2p+1 gets acc+rdata0+rdata1.
  - rdata1 is held in a register between the two writes.
- Arithmetic: acc saturates at 2^DATA_W-1. On saturation, cdf_overflow sets and stays set until the next start. Written values are the saturated values.
- cdf_min latches the first write whose wdata is nonzero (min_found gates further updates).
- cdf_total ← acc on entry to DONE.
- DONE → IDLE unconditionally. done=1 only in the DONE cycle.
- cdf_en falls while busy: abort to IDLE on the next edge.
  - WE=0 from that edge on; no done pulse.
  - cdf_min and cdf_total are left as-is; their contents are invalid.
- rst_n low in any state (including mid-pass): IDLE on the next edge; all outputs take their reset values.

## Timing
- Reset values: every output is 0 (addresses, wdata, WE, busy, done, cdf_min, cdf_total, cdf_overflow).
- Cycle 0 is the cycle in which start is sampled. busy goes high in cycle 1.
- Pair p:
  - raddr valid in cycle 2p+1;
  - rdata valid in cycle 2p+2;
  - WE=1 with waddr=2p in cycle 2p+3;
  - WE=1 with waddr=2p+1 in cycle 2p+4.
- WE is high continuously from cycle 3 through cycle BINS+2 (one bin per cycle).
- No hazard exists: the read in cycle 2p+3 targets bins 2p+2 and 2p+3, never the bin being written.
- done is high in cycle BINS+3 (259 for the defaults). busy falls in the same cycle done rises; cdf_total is valid in that cycle.
- raddr holds its last value outside read cycles. waddr and wdata hold their last values when WE=0.
- A new start is accepted in the cycle after done, giving back-to-back passes.

## Test plan
- All bins = 1, defaults:
  - memory holds bin i = i+1 after the pass;
  - cdf_min=1, cdf_total=256;
  - WE high cycles 3–258, done in cycle 259, cdf_overflow=0.
- Bins 0–4 = 0, bin 5 = 7, bin 200 = 3, rest 0:
  - bins 0–4 = 0, bins 5–199 = 7, bins 200–255 = 10;
  - cdf_min=7, cdf_total=10.
- DATA_W=8 with all bins = 2:
  - bin 126 = 254, bins 127–255 = 255;
  - cdf_overflow=1, cdf_total=255.
- start re-pulsed in cycle 50 is ignored (timing unchanged). cdf_en dropped in cycle 100:
  - WE=0 from cycle 101, busy=0, no done;
  - bins 0–96 are written, the rest untouched.
- rst_n low in cycle 80 of a pass: all outputs 0 on the next edge. A fresh start then completes normally with done at cycle 259.
- All-zero histogram: all bins stay 0; cdf_min=0, cdf_total=0, done in cycle 259.
